// File: rtl/ctrl_pipe.sv
// Control path of a 5-stage RV32I core: carries decode controls through E/M/W,
// resolves branches/jumps in E, and produces forwarding, stall and flush controls.
module ctrl_pipe #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        res_src_d,
    input  logic              mem_write_d,
    input  logic              alu_src_d,
    input  logic              reg_write_d,
    input  logic              jump_d,
    input  logic              jalr_d,
    input  logic              branch_d,
    input  logic [3:0]        alu_control_d,
    input  logic [2:0]        f3_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              zero_e,
    input  logic              lsb_e,
    output logic [1:0]        res_src_e,
    output logic [3:0]        alu_control_e,
    output logic              alu_src_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output logic [1:0]        pc_src_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              mem_write_m,
    output logic              reg_write_m,
    output logic [1:0]        res_src_m,
    output logic [REG_AW-1:0] rd_m,
    output logic              reg_write_w,
    output logic [1:0]        res_src_w,
    output logic [REG_AW-1:0] rd_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e
);

    logic [1:0]        res_src_e_q, res_src_m_q, res_src_w_q;
    logic              mem_write_e_q, mem_write_m_q;
    logic              reg_write_e_q, reg_write_m_q, reg_write_w_q;
    logic              alu_src_e_q, jump_e_q, jalr_e_q, branch_e_q;
    logic [3:0]        alu_control_e_q;
    logic [2:0]        f3_e_q;
    logic [REG_AW-1:0] rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;

    logic       taken;
    logic       redirect;
    logic       lwstall;
    logic [1:0] pc_src;

    // Pipeline registers; a flushed D->E transfer loads an all-zero bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_src_e_q     <= '0;
            mem_write_e_q   <= 1'b0;
            reg_write_e_q   <= 1'b0;
            alu_src_e_q     <= 1'b0;
            jump_e_q        <= 1'b0;
            jalr_e_q        <= 1'b0;
            branch_e_q      <= 1'b0;
            alu_control_e_q <= '0;
            f3_e_q          <= '0;
            rs1_e_q         <= '0;
            rs2_e_q         <= '0;
            rd_e_q          <= '0;
            res_src_m_q     <= '0;
            mem_write_m_q   <= 1'b0;
            reg_write_m_q   <= 1'b0;
            rd_m_q          <= '0;
            res_src_w_q     <= '0;
            reg_write_w_q   <= 1'b0;
            rd_w_q          <= '0;
        end else begin
            if (flush_e) begin
                res_src_e_q     <= '0;
                mem_write_e_q   <= 1'b0;
                reg_write_e_q   <= 1'b0;
                alu_src_e_q     <= 1'b0;
                jump_e_q        <= 1'b0;
                jalr_e_q        <= 1'b0;
                branch_e_q      <= 1'b0;
                alu_control_e_q <= '0;
                f3_e_q          <= '0;
                rs1_e_q         <= '0;
                rs2_e_q         <= '0;
                rd_e_q          <= '0;
            end else begin
                res_src_e_q     <= res_src_d;
                mem_write_e_q   <= mem_write_d;
                reg_write_e_q   <= reg_write_d;
                alu_src_e_q     <= alu_src_d;
                jump_e_q        <= jump_d;
                jalr_e_q        <= jalr_d;
                branch_e_q      <= branch_d;
                alu_control_e_q <= alu_control_d;
                f3_e_q          <= f3_d;
                rs1_e_q         <= rs1_d;
                rs2_e_q         <= rs2_d;
                rd_e_q          <= rd_d;
            end
            res_src_m_q   <= res_src_e_q;
            mem_write_m_q <= mem_write_e_q;
            reg_write_m_q <= reg_write_e_q;
            rd_m_q        <= rd_e_q;
            res_src_w_q   <= res_src_m_q;
            reg_write_w_q <= reg_write_m_q;
            rd_w_q        <= rd_m_q;
        end
    end

    // Branch condition from funct3; slt/sltu outcome arrives on lsb_e.
    always_comb begin
        taken = 1'b0;
        case (f3_e_q)
            3'b000:          taken = zero_e;
            3'b001:          taken = !zero_e;
            3'b100, 3'b110:  taken = lsb_e;
            3'b101, 3'b111:  taken = !lsb_e;
            default:         taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_src = 2'b00;
        if (jalr_e_q) begin
            pc_src = 2'b10;
        end else if (jump_e_q || (branch_e_q && taken)) begin
            pc_src = 2'b01;
        end
    end

    assign redirect = (pc_src != 2'b00);
    assign lwstall  = (res_src_e_q == 2'b01) && reg_write_e_q && (rd_e_q != '0) &&
                      ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));

    // A redirect squashes the stalled D instruction, so it overrides the stall.
    assign stall_f  = lwstall && !redirect;
    assign stall_d  = lwstall && !redirect;
    assign flush_d  = redirect;
    assign flush_e  = lwstall || redirect;
    assign pc_src_e = pc_src;

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (reg_write_m_q && (rd_m_q != '0) && (rd_m_q == rs1_e_q)) begin
            forward_a_e = 2'b10;
        end else if (reg_write_w_q && (rd_w_q != '0) && (rd_w_q == rs1_e_q)) begin
            forward_a_e = 2'b01;
        end
        if (reg_write_m_q && (rd_m_q != '0) && (rd_m_q == rs2_e_q)) begin
            forward_b_e = 2'b10;
        end else if (reg_write_w_q && (rd_w_q != '0) && (rd_w_q == rs2_e_q)) begin
            forward_b_e = 2'b01;
        end
    end

    assign res_src_e     = res_src_e_q;
    assign alu_control_e = alu_control_e_q;
    assign alu_src_e     = alu_src_e_q;
    assign rs1_e         = rs1_e_q;
    assign rs2_e         = rs2_e_q;
    assign rd_e          = rd_e_q;
    assign mem_write_m   = mem_write_m_q;
    assign reg_write_m   = reg_write_m_q;
    assign res_src_m     = res_src_m_q;
    assign rd_m          = rd_m_q;
    assign reg_write_w   = reg_write_w_q;
    assign res_src_w     = res_src_w_q;
    assign rd_w          = rd_w_q;

endmodule
